// File: rtl/seq_bit_serializer_if.sv
// Parallel-word handshake and serial output bundle for seq_bit_serializer.
interface seq_bit_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             out_bit;
  logic             out_valid;
  logic             frame_start;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  out_bit,
    input  out_valid,
    input  frame_start
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output out_bit,
    output out_valid,
    output frame_start
  );
endinterface

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer with a one-word hold buffer so consecutive words
// stream with no gap bits; bit order and idle level are parameters.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned IDLE_BIT  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_bit_serializer_if.slave  bus_if
);

  localparam int unsigned CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic IDLE_VAL        = (IDLE_BIT != 0);
  localparam logic MSB             = (MSB_FIRST != 0);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic             r_hold_full, w_hold_full_nxt;
  logic             r_out_bit, w_out_bit_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_frame_start, w_frame_start_nxt;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_load_word;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB ? w[WIDTH-1] : w[0];
  endfunction

  // Remaining bits after the current one has been presented.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign w_accept    = bus_if.data_valid & ~r_hold_full;
  assign w_last      = (r_cnt == LAST);
  assign w_load_word = r_hold_full ? r_hold : bus_if.data_in;

  assign bus_if.data_ready  = ~r_hold_full;
  assign bus_if.out_bit     = r_out_bit;
  assign bus_if.out_valid   = r_out_valid;
  assign bus_if.frame_start = r_frame_start;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: leave SHIFT only when the last bit ends with nothing queued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last && !r_hold_full && !w_accept) w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values; a word load presents its first bit immediately.
  always_comb begin
    w_shift_nxt       = r_shift;
    w_cnt_nxt         = r_cnt;
    w_hold_nxt        = r_hold;
    w_hold_full_nxt   = r_hold_full;
    w_out_bit_nxt     = IDLE_VAL;
    w_out_valid_nxt   = 1'b0;
    w_frame_start_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_shift_nxt       = advance(w_load_word);
          w_out_bit_nxt     = first_bit(w_load_word);
          w_cnt_nxt         = '0;
          w_out_valid_nxt   = 1'b1;
          w_frame_start_nxt = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!w_last) begin
          w_shift_nxt     = advance(r_shift);
          w_out_bit_nxt   = first_bit(r_shift);
          w_cnt_nxt       = CW'(r_cnt + 1'b1);
          w_out_valid_nxt = 1'b1;
          if (w_accept) begin
            w_hold_nxt      = bus_if.data_in;
            w_hold_full_nxt = 1'b1;
          end
        end else if (r_hold_full || w_accept) begin
          w_shift_nxt       = advance(w_load_word);
          w_out_bit_nxt     = first_bit(w_load_word);
          w_cnt_nxt         = '0;
          w_hold_full_nxt   = 1'b0;
          w_out_valid_nxt   = 1'b1;
          w_frame_start_nxt = 1'b1;
        end else begin
          w_shift_nxt = '0;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift       <= '0;
      r_cnt         <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_out_bit     <= IDLE_VAL;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_shift       <= w_shift_nxt;
      r_cnt         <= w_cnt_nxt;
      r_hold        <= w_hold_nxt;
      r_hold_full   <= w_hold_full_nxt;
      r_out_bit     <= w_out_bit_nxt;
      r_out_valid   <= w_out_valid_nxt;
      r_frame_start <= w_frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first/idle-0 and LSB-first/idle-1 instances.
module tb_seq_bit_serializer;

  logic clk;
  logic reset;

  seq_bit_serializer_if #(.WIDTH(8)) bus_m ();
  seq_bit_serializer_if #(.WIDTH(8)) bus_l ();

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(0)) dut_m (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_m)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1)) dut_l (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       dv;
    logic [7:0] din;
    logic [3:0] exp;   // {data_ready, out_bit, out_valid, frame_start}
  } vec_t;

  vec_t tbl [27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] obs_m();
    return {bus_m.data_ready, bus_m.out_bit, bus_m.out_valid, bus_m.frame_start};
  endfunction

  function automatic logic [3:0] obs_l();
    return {bus_l.data_ready, bus_l.out_bit, bus_l.out_valid, bus_l.frame_start};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] words [3];
    logic [7:0] cur;
    logic [7:0] seq030;
    logic [3:0] hist;
    int         nbits;
    int         hits;
    logic [31:0] hit_mask;
    logic       exp_rdy;

    // Back-to-back B0/0D with hold buffer, junk data while not ready, then a
    // direct load on the last-bit edge followed by return to idle.
    tbl[0]  = '{1'b1, 8'hB0, 4'b1000};
    tbl[1]  = '{1'b1, 8'h0D, 4'b1111};
    tbl[2]  = '{1'b1, 8'hFF, 4'b0010};
    tbl[3]  = '{1'b1, 8'hFF, 4'b0110};
    tbl[4]  = '{1'b1, 8'hFF, 4'b0110};
    tbl[5]  = '{1'b1, 8'hFF, 4'b0010};
    tbl[6]  = '{1'b1, 8'hFF, 4'b0010};
    tbl[7]  = '{1'b1, 8'hFF, 4'b0010};
    tbl[8]  = '{1'b1, 8'hFF, 4'b0010};
    tbl[9]  = '{1'b0, 8'h00, 4'b1011};
    tbl[10] = '{1'b0, 8'h00, 4'b1010};
    tbl[11] = '{1'b0, 8'h00, 4'b1010};
    tbl[12] = '{1'b0, 8'h00, 4'b1010};
    tbl[13] = '{1'b0, 8'h00, 4'b1110};
    tbl[14] = '{1'b0, 8'h00, 4'b1110};
    tbl[15] = '{1'b0, 8'h00, 4'b1010};
    tbl[16] = '{1'b1, 8'hB0, 4'b1110};
    tbl[17] = '{1'b0, 8'h00, 4'b1111};
    tbl[18] = '{1'b0, 8'h00, 4'b1010};
    tbl[19] = '{1'b0, 8'h00, 4'b1110};
    tbl[20] = '{1'b0, 8'h00, 4'b1110};
    tbl[21] = '{1'b0, 8'h00, 4'b1010};
    tbl[22] = '{1'b0, 8'h00, 4'b1010};
    tbl[23] = '{1'b0, 8'h00, 4'b1010};
    tbl[24] = '{1'b0, 8'h00, 4'b1010};
    tbl[25] = '{1'b0, 8'h00, 4'b1000};
    tbl[26] = '{1'b0, 8'h00, 4'b1000};

    reset            = 1'b0;
    bus_m.data_valid = 1'b0;
    bus_m.data_in    = 8'h00;
    bus_l.data_valid = 1'b0;
    bus_l.data_in    = 8'h00;

    @(negedge clk);
    check("reset_m", 32'(obs_m()), 32'(4'b1000));
    check("reset_l", 32'(obs_l()), 32'(4'b1100));
    reset = 1'b1;

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(obs_m()), 32'(tbl[i].exp));
      bus_m.data_valid = tbl[i].dv;
      bus_m.data_in    = tbl[i].din;
    end

    // Word accepted at counter 3, next word blocked until the last-bit edge.
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    words[2] = 8'h81;
    @(negedge clk);
    check("pre_hold_idle", 32'(obs_m()), 32'(4'b1000));
    bus_m.data_valid = 1'b1;
    bus_m.data_in    = words[0];
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      cur     = words[k / 8];
      exp_rdy = (k < 4) || (k == 8) || (k >= 16);
      check($sformatf("hold_seq_k%0d", k), 32'(obs_m()),
            32'({exp_rdy, cur[7 - (k % 8)], 1'b1, (k % 8) == 0}));
      if (k == 3) begin
        bus_m.data_valid = 1'b1;
        bus_m.data_in    = words[1];
      end else if (k >= 4 && k <= 8) begin
        bus_m.data_valid = 1'b1;
        bus_m.data_in    = words[2];
      end else begin
        bus_m.data_valid = 1'b0;
        bus_m.data_in    = 8'h00;
      end
    end
    @(negedge clk);
    check("post_hold_idle", 32'(obs_m()), 32'(4'b1000));

    // Reset at counter 4 with the hold buffer full.
    bus_m.data_valid = 1'b1;
    bus_m.data_in    = 8'hF0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      bus_m.data_valid = (k == 0);
      bus_m.data_in    = (k == 0) ? 8'hFF : 8'h00;
    end
    check("pre_reset_cnt4", 32'(obs_m()), 32'(4'b0010));
    #2 reset = 1'b0;
    #1;
    check("reset_async_m", 32'(obs_m()), 32'(4'b1000));
    check("reset_async_l", 32'(obs_l()), 32'(4'b1100));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("post_reset_quiet%0d", k), 32'(obs_m()), 32'(4'b1000));
    end
    bus_m.data_valid = 1'b1;
    bus_m.data_in    = 8'h5A;
    cur = 8'h5A;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus_m.data_valid = 1'b0;
      check($sformatf("post_reset_word_k%0d", k), 32'(obs_m()),
            32'({1'b1, cur[7 - k], 1'b1, k == 0}));
    end
    @(negedge clk);
    check("post_reset_word_idle", 32'(obs_m()), 32'(4'b1000));

    // LSB-first instance with idle level 1.
    seq030 = 8'b1011_0000;
    bus_l.data_valid = 1'b1;
    bus_l.data_in    = 8'h0D;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus_l.data_valid = 1'b0;
      check($sformatf("lsb_first_k%0d", k), 32'(obs_l()),
            32'({1'b1, seq030[7 - k], 1'b1, k == 0}));
    end
    @(negedge clk);
    check("lsb_first_idle", 32'(obs_l()), 32'(4'b1100));

    // Two B0 words into a 1011 pattern detector model.
    hist     = 4'b0000;
    nbits    = 0;
    hits     = 0;
    hit_mask = 32'h0;
    bus_m.data_valid = 1'b1;
    bus_m.data_in    = 8'hB0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      bus_m.data_valid = (k == 0);
      bus_m.data_in    = (k == 0) ? 8'hB0 : 8'h00;
      if (bus_m.out_valid) begin
        hist = {hist[2:0], bus_m.out_bit};
        nbits++;
        if (nbits >= 4 && hist == 4'b1011) begin
          hits++;
          hit_mask[nbits] = 1'b1;
        end
      end
    end
    check("detect_hits", 32'(hits), 32'd2);
    check("detect_valid_bits", 32'(nbits), 32'd16);
    check("detect_hit_pos", hit_mask, 32'h0000_1010);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
